// File: rtl/fp_norm_pipe.sv
// Three-stage normaliser: signed-magnitude product -> two's-complement
// MO_W-bit mantissa with round-half-up, exponent adjust and range flags.
module fp_norm_pipe #(
  parameter int unsigned MA_W = 30,
  parameter int unsigned EA_W = 10,
  parameter int unsigned MO_W = 16,
  parameter int unsigned EO_W = 8,
  parameter bit          SAT  = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [MA_W-1:0] in_ma,
  input  logic [EA_W-1:0] in_ea,
  input  logic            in_sign,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [MO_W-1:0] out_ma,
  output logic [EO_W-1:0] out_ea,
  output logic            out_over_flow,
  output logic            out_under_flow
);

  localparam int unsigned V_W  = MA_W + 1;
  localparam int unsigned SH_W = $clog2(MA_W - MO_W + 3);
  localparam int unsigned E_W  = EA_W + 1;

  localparam logic signed [E_W-1:0] E_MAX = E_W'((1 << (EO_W - 1)) - 1);
  localparam logic signed [E_W-1:0] E_MIN = E_W'(-(1 << (EO_W - 1)));

  localparam logic [MO_W-1:0] M_POS_MAX = {1'b0, {(MO_W-1){1'b1}}};
  localparam logic [MO_W-1:0] M_NEG_MAX = {1'b1, {(MO_W-1){1'b0}}};
  localparam logic [MO_W-1:0] M_HALF    = {2'b01, {(MO_W-2){1'b0}}};
  localparam logic [EO_W-1:0] E_OUT_MAX = {1'b0, {(EO_W-1){1'b1}}};

  // stage registers
  logic            s1_valid;
  logic [V_W-1:0]  s1_v;
  logic [EA_W-1:0] s1_ea;
  logic            s1_sign;
  logic            s1_zero;

  logic            s2_valid;
  logic [MO_W-1:0] s2_m;
  logic            s2_r;
  logic [SH_W-1:0] s2_sh;
  logic [EA_W-1:0] s2_ea;
  logic            s2_sign;
  logic            s2_zero;

  // stage enables and combinational stage results
  logic            s1_en;
  logic            s2_en;
  logic            s3_en;
  logic [V_W-1:0]  v_n;
  logic [SH_W-1:0] sh_n;
  logic [MO_W:0]   mr_n;
  logic [MO_W-1:0] m_rnd;
  logic [SH_W-1:0] sh_adj;
  logic signed [E_W-1:0] e_n;
  logic            ovf_n;
  logic            unf_n;
  logic [MO_W-1:0] ma_n;
  logic [EO_W-1:0] ea_n;

  // a stage loads when empty or when its word moves on this cycle
  always_comb begin
    s3_en    = !out_valid || out_ready;
    s2_en    = !s2_valid || s3_en;
    s1_en    = !s1_valid || s2_en;
    in_ready = s1_en;
  end

  // S1 input conversion to two's complement
  always_comb begin
    v_n = '0;
    if (in_ma != '0) begin
      v_n = in_sign ? -{1'b0, in_ma} : {1'b0, in_ma};
    end
  end

  // S1 register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_v     <= '0;
      s1_ea    <= '0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      s1_v     <= v_n;
      s1_ea    <= in_ea;
      s1_sign  <= in_sign;
      s1_zero  <= (in_ma == '0);
    end
  end

  // S2 leading-sign detect; the highest differing bit lands at MO_W-2
  always_comb begin
    sh_n = '0;
    for (int i = int'(MO_W) - 1; i < int'(MA_W); i++) begin
      if (s1_v[i] != s1_v[MA_W]) begin
        sh_n = SH_W'(i - (int'(MO_W) - 2));
      end
    end
    mr_n = (MO_W+1)'({s1_v, 1'b0} >> sh_n);
  end

  // S2 register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_m     <= '0;
      s2_r     <= 1'b0;
      s2_sh    <= '0;
      s2_ea    <= '0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      s2_m     <= mr_n[MO_W:1];
      s2_r     <= mr_n[0];
      s2_sh    <= sh_n;
      s2_ea    <= s1_ea;
      s2_sign  <= s1_sign;
      s2_zero  <= s1_zero;
    end
  end

  // S3 rounding, exponent adjust, range check and saturation
  always_comb begin
    m_rnd  = s2_m + MO_W'(s2_r);
    sh_adj = s2_sh;
    if (s2_r && (s2_m == M_POS_MAX)) begin
      m_rnd  = M_HALF;
      sh_adj = s2_sh + SH_W'(1);
    end
    e_n   = {s2_ea[EA_W-1], s2_ea} + E_W'(sh_adj);
    ovf_n = (e_n > E_MAX);
    unf_n = (e_n < E_MIN);
    ma_n  = m_rnd;
    ea_n  = e_n[EO_W-1:0];
    if (s2_zero) begin
      ma_n  = '0;
      ea_n  = '0;
      ovf_n = 1'b0;
      unf_n = 1'b0;
    end else if (SAT) begin
      if (ovf_n) begin
        ma_n = s2_sign ? M_NEG_MAX : M_POS_MAX;
        ea_n = E_OUT_MAX;
      end else if (unf_n) begin
        ma_n = '0;
        ea_n = '0;
      end
    end
  end

  // S3 output register; flags only ever set alongside a valid word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_ma         <= '0;
      out_ea         <= '0;
      out_over_flow  <= 1'b0;
      out_under_flow <= 1'b0;
    end else if (s3_en) begin
      out_valid      <= s2_valid;
      out_ma         <= ma_n;
      out_ea         <= ea_n;
      out_over_flow  <= s2_valid && ovf_n;
      out_under_flow <= s2_valid && unf_n;
    end
  end

endmodule
